barrel_shift_pipe: RTL and testbench

Pipelined, parametrised barrel shifter/rotator with a valid/ready stream interface. It generalises the combinational left and right rotators to five operations: rotate left, rotate right, logical left, logical right, and arithmetic right. Data width is 2**AMT_WIDTH and the number of register stages is configurable. It sits between an operand source and a result consumer (ALU/datapath), accepts one operation per cycle at full throughput, and tolerates backpressure.

---
 rtl/shift_pkg.sv | 40 ++++
 rtl/barrel_shift_pipe_if.sv | 29 ++
 rtl/barrel_stage.sv | 37 +++
 rtl/barrel_shift_pipe.sv | 117 +++++++++++
 tb/tb_barrel_shift_pipe.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Holds the op encoding and the level-to-stage split functions.
package shift_pkg;

  typedef enum logic [2:0] {
    OP_ROL  = 3'd0,
    OP_ROR  = 3'd1,
    OP_SLL  = 3'd2,
    OP_SRL  = 3'd3,
    OP_SRA  = 3'd4,
    OP_PASS = 3'd5
  } shift_op_t;

  function automatic logic is_left(shift_op_t op);
    return (op == OP_ROL) || (op == OP_SLL);
  endfunction

  // Codes 101..111 all bypass.
  function automatic logic is_pass(shift_op_t op);
    return 3'(op) >= 3'(OP_PASS);
  endfunction

  // Earlier stages take one extra level until the remainder runs out.
  function automatic int levels_in_stage(int s, int l, int n);
    int base;
    int rem;
    base = l / n;
    rem  = l % n;
    return base + ((s < rem) ? 1 : 0);
  endfunction

  function automatic int first_level(int s, int l, int n);
    int f;
    f = 0;
    for (int i = 0; i < s; i++)
      f += levels_in_stage(i, l, n);
    return f;
  endfunction

endpackage

// File: rtl/barrel_shift_pipe_if.sv
// Stream bundle for barrel_shift_pipe: operand side and result side.
// slave = shifter (in_ready/out_valid/out_data out), master = driver.
interface barrel_shift_pipe_if
  import shift_pkg::*;
#(
  parameter int AMT_WIDTH = 5
);
  localparam int WIDTH = 2 ** AMT_WIDTH;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [AMT_WIDTH-1:0] in_amt;
  shift_op_t            in_op;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;

  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/barrel_stage.sv
// Combinational slice applying right-move levels LO..HI to d.
// Ports: d, amt[HI:LO], op, sign in; y out.
module barrel_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LO    = 0,
  parameter int HI    = 0
) (
  input  logic [WIDTH-1:0] d,
  input  logic [HI:LO]     amt,
  input  shift_op_t        op,
  input  logic             sign,
  output logic [WIDTH-1:0] y
);

  logic             rot;
  logic             fill;
  logic [WIDTH-1:0] ones;

  always_comb begin
    rot  = (op == OP_ROL) || (op == OP_ROR);
    fill = (op == OP_SRA) && sign;
    ones = '1;
    y    = d;
    for (int k = LO; k <= HI; k++) begin
      if (amt[k]) begin
        if (rot)
          y = (y >> (2 ** k)) | (y << (WIDTH - 2 ** k));
        else
          y = (y >> (2 ** k))
            | (fill ? ~(ones >> (2 ** k)) : '0);
      end
    end
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined rotate/shift unit, STAGES register stages, valid/ready.
// Ports: clk, reset (sync, high), bus (slave side of the stream bundle).
module barrel_shift_pipe
  import shift_pkg::*;
#(
  parameter int AMT_WIDTH = 5,
  parameter int STAGES    = 2
) (
  input logic                clk,
  input logic                reset,
  barrel_shift_pipe_if.slave bus
);

  localparam int WIDTH = 2 ** AMT_WIDTH;

  typedef struct packed {
    logic [WIDTH-1:0]     data;
    logic [AMT_WIDTH-1:0] amt;
    shift_op_t            op;
    logic                 sign;
  } pipe_t;

  function automatic logic [WIDTH-1:0] rev(
    input logic [WIDTH-1:0] x
  );
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++)
      r[i] = x[WIDTH-1-i];
    return r;
  endfunction

  pipe_t entry;
  pipe_t src  [STAGES];
  pipe_t nxt  [STAGES];
  pipe_t q    [STAGES];
  logic  srcv [STAGES];
  logic  vld  [STAGES];
  logic  rdy  [STAGES];

  // Left ops are mirrored so the core only moves right;
  // PASS zeroes the amount so no level touches the data.
  always_comb begin
    entry.op   = bus.in_op;
    entry.sign = bus.in_data[WIDTH-1];
    entry.amt  = is_pass(bus.in_op) ? '0 : bus.in_amt;
    entry.data = is_left(bus.in_op) ? rev(bus.in_data)
                                    : bus.in_data;
  end

  always_comb begin
    src[0]  = entry;
    srcv[0] = bus.in_valid;
    for (int s = 1; s < STAGES; s++) begin
      src[s]  = q[s-1];
      srcv[s] = vld[s-1];
    end
  end

  // Stage s can load if out_ready or any slot from s down is empty.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      rdy[s] = bus.out_ready;
      for (int j = s; j < STAGES; j++)
        if (!vld[j]) rdy[s] = 1'b1;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int LO = first_level(s, AMT_WIDTH, STAGES);
    localparam int HI =
      LO + levels_in_stage(s, AMT_WIDTH, STAGES) - 1;

    logic [WIDTH-1:0] y;

    barrel_stage #(
      .WIDTH (WIDTH),
      .LO    (LO),
      .HI    (HI)
    ) u_stage (
      .d    (src[s].data),
      .amt  (src[s].amt[HI:LO]),
      .op   (src[s].op),
      .sign (src[s].sign),
      .y    (y)
    );

    assign nxt[s] = '{
      data: y,
      amt:  src[s].amt,
      op:   src[s].op,
      sign: src[s].sign
    };
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) begin
        vld[s] <= 1'b0;
        q[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (rdy[s]) begin
          vld[s] <= srcv[s];
          if (srcv[s]) q[s] <= nxt[s];
        end
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld[STAGES-1];
  assign bus.out_data  = is_left(q[STAGES-1].op)
                       ? rev(q[STAGES-1].data)
                       : q[STAGES-1].data;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Scoreboard bench for barrel_shift_pipe (AMT_WIDTH=5, STAGES=2).
// Driver pushes expected results; a negedge monitor pops and compares.
module tb_barrel_shift_pipe;
  import shift_pkg::*;

  logic clk;
  logic reset;
  int   cyc;
  int   ncmp;
  int   nmis;

  typedef struct {
    logic [31:0] data;
    bit          chk;
    int          acc;
  } exp_t;

  exp_t sb[$];

  bit win;
  int vcnt;
  bit rnd_on;

  barrel_shift_pipe_if #(.AMT_WIDTH(5)) bus ();

  barrel_shift_pipe #(
    .AMT_WIDTH (5),
    .STAGES    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(
    shift_op_t op, logic [31:0] d, logic [4:0] a
  );
    logic [63:0] t;
    case (op)
      OP_ROL: begin t = {d, d} << a; return t[63:32]; end
      OP_ROR: begin t = {d, d} >> a; return t[31:0]; end
      OP_SLL: return d << a;
      OP_SRL: return d >> a;
      OP_SRA: return $signed(d) >>> a;
      default: return d;
    endcase
  endfunction

  // Monitor: every valid cycle must show the scoreboard head.
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      ncmp++;
      if (sb.size() == 0) begin
        nmis++;
        $display("FAIL unexpected_output got=%h expected=none",
                 bus.out_data);
      end else begin
        if (bus.out_data !== sb[0].data) begin
          nmis++;
          $display("FAIL out_data got=%h expected=%h",
                   bus.out_data, sb[0].data);
        end
        if (bus.out_ready) begin
          if (sb[0].chk) begin
            ncmp++;
            if (cyc - sb[0].acc != 2) begin
              nmis++;
              $display("FAIL latency got=%0d expected=2",
                       cyc - sb[0].acc);
            end
          end
          void'(sb.pop_front());
        end
      end
    end
  end

  always @(negedge clk)
    if (win && bus.out_valid) vcnt++;

  task automatic send(
    input  shift_op_t   op,
    input  logic [31:0] d,
    input  logic [4:0]  a,
    input  logic [31:0] exp,
    input  bit          chk,
    output int          waits
  );
    logic ok;
    ok    = 1'b0;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = d;
    bus.in_amt   = a;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
      if (ok) sb.push_back('{exp, chk, cyc});
      @(posedge clk);
      #1;
      if (ok) break;
      waits++;
    end
    if (!ok) begin
      ncmp++;
      nmis++;
      $display("FAIL send_timeout got=stalled expected=accept");
    end
  endtask

  task automatic idle_cycles(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int t = 0; t < 500 && sb.size() > 0; t++)
      @(posedge clk);
    #1;
    ncmp++;
    if (sb.size() != 0) begin
      nmis++;
      $display("FAIL drain_timeout got=%0d pending expected=0",
               sb.size());
    end
  endtask

  task automatic check1(
    input string nm, input logic [31:0] got, input logic [31:0] want
  );
    ncmp++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s got=%h expected=%h", nm, got, want);
    end
  endtask

  typedef struct {
    shift_op_t   op;
    logic [31:0] d;
    logic [4:0]  a;
    logic [31:0] e;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int w;
    int wsum;
    shift_op_t op;
    logic [31:0] d;
    logic [4:0] a;

    vecs[0] = '{OP_ROL, 32'h8000_0001, 5'd1,  32'h0000_0003};
    vecs[1] = '{OP_ROR, 32'h0000_0001, 5'd4,  32'h1000_0000};
    vecs[2] = '{OP_ROL, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[3] = '{OP_SLL, 32'h0000_000F, 5'd28, 32'hF000_0000};
    vecs[4] = '{OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001};
    vecs[5] = '{OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[6] = '{OP_SRA, 32'h4000_0000, 5'd30, 32'h0000_0001};
    vecs[7] = '{OP_PASS, 32'hDEAD_BEEF, 5'd7, 32'hDEAD_BEEF};
    vecs[8] = '{shift_op_t'(3'b111), 32'h1234_5678, 5'd31,
                32'h1234_5678};
    vecs[9] = '{OP_SRA, 32'hF000_0000, 5'd0,  32'hF000_0000};

    cyc = 0; ncmp = 0; nmis = 0;
    win = 0; vcnt = 0; rnd_on = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_op     = OP_ROL;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check1("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check1("reset_out_data", bus.out_data, 32'd0);
    check1("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors, back to back, latency checked.
    bus.out_ready = 1'b1;
    foreach (vecs[i])
      send(vecs[i].op, vecs[i].d, vecs[i].a, vecs[i].e, 1'b1, w);
    drain();

    // Throughput: 16 random ops with the sink always ready.
    win = 1; vcnt = 0; wsum = 0;
    for (int i = 0; i < 16; i++) begin
      op = shift_op_t'(3'($urandom_range(0, 7)));
      d  = $urandom();
      a  = 5'($urandom_range(0, 31));
      send(op, d, a, model(op, d, a), 1'b1, w);
      wsum += w;
    end
    drain();
    idle_cycles(2);
    win = 0;
    check1("tput_valid_cycles", vcnt, 32'd16);
    check1("tput_stalls", wsum, 32'd0);

    // Backpressure: two fill the pipe, third waits.
    bus.out_ready = 1'b0;
    send(OP_ROR, 32'h0000_00F0, 5'd4, 32'h0000_000F, 1'b0, w);
    send(OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, w);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_SRA;
    bus.in_data  = 32'h8000_0010;
    bus.in_amt   = 5'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check1("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check1("bp_held_data", bus.out_data, 32'h0000_000F);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(OP_SRA, 32'h8000_0010, 5'd4, 32'hF800_0001, 1'b0, w);
    drain();

    // Reset with two ops in flight.
    bus.out_ready = 1'b0;
    send(OP_ROL, 32'hAAAA_0000, 5'd8, 32'hAA00_00AA, 1'b0, w);
    send(OP_SRL, 32'hFFFF_FFFF, 5'd16, 32'h0000_FFFF, 1'b0, w);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check1("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check1("rst_out_data", bus.out_data, 32'd0);
    check1("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    idle_cycles(6);

    // Random regression with random source gaps and sink stalls.
    rnd_on = 1;
    fork
      while (rnd_on) begin
        @(posedge clk);
        #1;
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycles(1);
      op = shift_op_t'(3'($urandom_range(0, 7)));
      d  = $urandom();
      a  = 5'($urandom_range(0, 31));
      send(op, d, a, model(op, d, a), 1'b0, w);
    end
    rnd_on = 0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 bus.out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nmis);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
